// File: rtl/nibble_sweep_ctrl_pkg.sv
// Shared definitions for the nibble sweep sequencer: state encoding,
// code range and the sample-accumulate helper.
package nibble_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Highest code driven to the decode block; reaching it ends a sweep.
    localparam logic [3:0] LAST_CODE = 4'd15;

    // Width of the per-LED hit counters; 16 hits fit without wrapping.
    localparam int CNT_W = 5;

    // Add one LED sample to a hit accumulator.
    function automatic logic [CNT_W-1:0] add_hit(input logic [CNT_W-1:0] acc,
                                                 input logic             hit);
        return acc + {{(CNT_W-1){1'b0}}, hit};
    endfunction

endpackage

// File: rtl/nibble_sweep_ctrl_if.sv
// Control handshake and decode-block bus of the nibble sweep sequencer.
// The slave side is the sequencer; the master side is the board logic
// (buttons/switches plus the LED decode block).
interface nibble_sweep_ctrl_if;

    logic       start;
    logic       stop;
    logic       loop;
    logic       led1_in;
    logic       led2_in;
    logic [3:0] a_out;
    logic       busy;
    logic       done;
    logic       sweep_pulse;
    logic [4:0] led1_count;
    logic [4:0] led2_count;

    modport master (
        output start, stop, loop, led1_in, led2_in,
        input  a_out, busy, done, sweep_pulse, led1_count, led2_count
    );

    modport slave (
        input  start, stop, loop, led1_in, led2_in,
        output a_out, busy, done, sweep_pulse, led1_count, led2_count
    );

endinterface

// File: rtl/nibble_sweep_ctrl_dwell_timer.sv
// Reusable dwell timer: counts 0..DWELL_CYCLES-1 while enabled and flags
// the terminal cycle. The count wraps to 0 on its own after the terminal
// cycle, so back-to-back dwell periods need no extra clear.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int DWELL_W      = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    // Dwell counter: clear has priority, otherwise advance and wrap at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nibble_sweep_ctrl.sv
// Nibble sweep sequencer: steps the decode block's 4-bit input through
// codes 0..15, holding each for DWELL_CYCLES clocks, samples led1/led2 at
// the end of every dwell and latches per-LED hit counts once per sweep.
// Supports single-sweep and continuous-loop operation.
module nibble_sweep_ctrl
    import nibble_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int DWELL_W      = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_sweep_ctrl_if.slave   io
);

    state_t           state;
    logic [3:0]       code;
    logic [CNT_W-1:0] acc1;
    logic [CNT_W-1:0] acc2;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             busy_q;
    logic             done_q;
    logic             pulse_q;
    logic             loop_q;
    logic             tc;
    logic             tmr_clr;
    logic             tmr_en;

    // The timer only runs in RUN; leaving RUN (or a stop) parks it at 0 so
    // the first code of the next sweep gets a full dwell.
    assign tmr_en  = (state == RUN);
    assign tmr_clr = io.stop || (state != RUN);

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .DWELL_W      (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tc)
    );

    assign io.a_out       = code;
    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.sweep_pulse = pulse_q;
    assign io.led1_count  = cnt1;
    assign io.led2_count  = cnt2;

    // Sequencer FSM with registered outputs; stop overrides everything and
    // the latched counts survive a stop so the last result stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= '0;
            acc1    <= '0;
            acc2    <= '0;
            cnt1    <= '0;
            cnt2    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (io.stop) begin
                state  <= IDLE;
                code   <= '0;
                acc1   <= '0;
                acc2   <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (io.start) begin
                            state  <= RUN;
                            code   <= '0;
                            acc1   <= '0;
                            acc2   <= '0;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            loop_q <= io.loop;
                        end
                    end
                    RUN: begin
                        if (tc) begin
                            if (code != LAST_CODE) begin
                                code <= code + 1'b1;
                                acc1 <= add_hit(acc1, io.led1_in);
                                acc2 <= add_hit(acc2, io.led2_in);
                            end else begin
                                // Sweep end: publish totals including this sample.
                                cnt1    <= add_hit(acc1, io.led1_in);
                                cnt2    <= add_hit(acc2, io.led2_in);
                                pulse_q <= 1'b1;
                                code    <= '0;
                                acc1    <= '0;
                                acc2    <= '0;
                                if (!loop_q) begin
                                    state  <= DONE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nibble_sweep_ctrl.sv
// Self-checking bench for nibble_sweep_ctrl with DWELL_CYCLES=4. The decode
// block is modelled as two 16-bit lookup masks (bit n = LED state for code n),
// so expected counts are simply the popcount of each mask and the expected
// code at RUN cycle k is (k/4) mod 16.
module tb_nibble_sweep_ctrl;
    import nibble_sweep_ctrl_pkg::*;

    localparam int DWELL = 4;
    localparam int SWEEP = 16 * DWELL;

    logic        clk;
    logic        rst_n;
    logic [15:0] mask1;
    logic [15:0] mask2;
    int          total;
    int          bad;

    nibble_sweep_ctrl_if io ();

    assign io.led1_in = mask1[io.a_out];
    assign io.led2_in = mask2[io.a_out];

    nibble_sweep_ctrl #(
        .DWELL_CYCLES (DWELL),
        .DWELL_W      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Counts latched by the last completed sweep, as the model sees it.
    int exp_c1;
    int exp_c2;

    task automatic pulse_start(input bit lp, input bit with_stop);
        @(negedge clk);
        io.start = 1'b1;
        io.stop  = with_stop;
        io.loop  = lp;
        @(negedge clk);
        io.start = 1'b0;
        io.stop  = 1'b0;
        io.loop  = ~lp;   // must be ignored once latched
    endtask

    task automatic do_stop();
        io.stop = 1'b1;
        @(negedge clk);
        io.stop = 1'b0;
        chk("stop_busy", io.busy, 0);
        chk("stop_done", io.done, 0);
        chk("stop_a", io.a_out, 0);
        chk("stop_c1", io.led1_count, exp_c1);
        chk("stop_c2", io.led2_count, exp_c2);
    endtask

    // Run nsw sweeps from IDLE/DONE, checking every cycle; optionally inject
    // a start pulse at RUN cycle 21 (code 5), which must be ignored.
    task automatic run_sweep(input bit lp, input int nsw, input bit inj);
        int c1;
        int c2;
        c1 = $countones(mask1);
        c2 = $countones(mask2);
        pulse_start(lp, 1'b0);
        for (int k = 0; k <= SWEEP * nsw; k++) begin
            chk("a_out", io.a_out, (k / DWELL) % 16);
            chk("busy", io.busy, (lp || k < SWEEP * nsw) ? 1 : 0);
            chk("done", io.done, (!lp && k == SWEEP * nsw) ? 1 : 0);
            chk("pulse", io.sweep_pulse, (k > 0 && k % SWEEP == 0) ? 1 : 0);
            if (k > 0 && k % SWEEP == 0) begin
                chk("cnt1", io.led1_count, c1);
                chk("cnt2", io.led2_count, c2);
            end
            io.start = (inj && k == 21);
            @(negedge clk);
        end
        io.start = 1'b0;
        exp_c1 = c1;
        exp_c2 = c2;
        chk("pulse_after", io.sweep_pulse, 0);
        if (!lp) begin
            chk("done_hold", io.done, 1);
            chk("busy_after", io.busy, 0);
        end
    endtask

    initial begin
        int lp;
        int nsw;
        total    = 0;
        bad      = 0;
        exp_c1   = 0;
        exp_c2   = 0;
        io.start = 1'b0;
        io.stop  = 1'b0;
        io.loop  = 1'b0;
        mask1    = 16'hAAAA;   // led1 = a[0]
        mask2    = 16'hFC00;   // led2 = (a > 9)
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a", io.a_out, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_done", io.done, 0);
        chk("rst_c1", io.led1_count, 0);
        chk("rst_c2", io.led2_count, 0);
        chk("rst_pulse", io.sweep_pulse, 0);

        // Single sweep with the reference decode: expect 8 / 6.
        run_sweep(1'b0, 1, 1'b0);
        chk("single_c1", io.led1_count, 8);
        chk("single_c2", io.led2_count, 6);

        // Continuous mode, two sweeps, then stop; counts must hold.
        run_sweep(1'b1, 2, 1'b0);
        do_stop();

        // Stop mid-sweep at code 7 with a different decode: counts stay 8/6.
        mask1 = 16'($urandom);
        mask2 = 16'($urandom);
        pulse_start(1'b0, 1'b0);
        repeat (29) @(negedge clk);
        chk("pre_stop_a", io.a_out, 7);
        do_stop();
        for (int k = 0; k < SWEEP + 8; k++) begin
            chk("idle_pulse", io.sweep_pulse, 0);
            chk("idle_a", io.a_out, 0);
            @(negedge clk);
        end

        // start and stop together from IDLE: stop wins.
        pulse_start(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("ss_busy", io.busy, 0);
            chk("ss_a", io.a_out, 0);
            @(negedge clk);
        end

        // start during RUN at code 5 is ignored.
        run_sweep(1'b0, 1, 1'b1);

        // Randomized sweeps with random decode masks and modes.
        for (int it = 0; it < 5; it++) begin
            mask1 = 16'($urandom);
            mask2 = 16'($urandom);
            if (it == 0) mask1 = 16'hFFFF;   // 16 hits: counter top end
            if (it == 1) mask2 = 16'h0000;
            lp  = $urandom_range(0, 1);
            nsw = (lp != 0) ? $urandom_range(1, 2) : 1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(lp[0], nsw, $urandom_range(0, 1) != 0);
            if (lp != 0) do_stop();
        end

        // Asynchronous reset mid-sweep: outputs clear without a clock edge.
        pulse_start(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        chk("pre_rst_a", io.a_out, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", io.a_out, 0);
        chk("arst_busy", io.busy, 0);
        chk("arst_done", io.done, 0);
        chk("arst_c1", io.led1_count, 0);
        chk("arst_c2", io.led2_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", io.busy, 0);
        chk("post_rst_a", io.a_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
